// File: rtl/nios_pio_pkg.sv
// Shared definitions for the Nios input/output PIO register blocks:
// register word addresses, edge-select encodings and arming states.
package nios_pio_pkg;

    localparam logic [1:0] ADDR_DATA         = 2'd0;
    localparam logic [1:0] ADDR_RESERVED     = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK     = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAPTURE = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISING  = 2'd0,
        EDGE_FALLING = 2'd1,
        EDGE_ANY     = 2'd2
    } edge_type_e;

    typedef enum logic {
        ARM_WAIT  = 1'b0,
        ARM_READY = 1'b1
    } arm_state_e;

endpackage

// File: rtl/nios_pio_sync.sv
// Multi-stage input synchroniser with a one-clock delayed sample and an
// arm flag that rises SYNC_STAGES+1 clocks after reset deasserts.
module nios_pio_sync
    import nios_pio_pkg::*;
#(
    parameter int DATA_WIDTH  = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] sync_o,
    output logic [DATA_WIDTH-1:0] sync_d_o,
    output logic                  armed_o
);

    localparam int CW = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SYNC_STAGES);

    logic [DATA_WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] sync_d_q;
    arm_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
            sync_d_q <= '0;
        end else begin
            stage_q[0] <= data_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            sync_d_q <= stage_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ARM_WAIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Holding off until the chain has flushed hides the 0->bus transition
    // that appears when reset releases with the bus already driven.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARM_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ARM_READY;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ARM_READY: begin
                state_d = ARM_READY;
            end
            default: begin
                state_d = ARM_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign sync_o   = stage_q[SYNC_STAGES-1];
    assign sync_d_o = sync_d_q;
    assign armed_o  = (state_q == ARM_READY);

endmodule

// File: rtl/nios_pio_capture_in.sv
// Avalon-MM input PIO: synchronised data, irq mask and write-1-to-clear
// edge capture register with a level interrupt.
module nios_pio_capture_in
    import nios_pio_pkg::*;
#(
    parameter int DATA_WIDTH  = 12,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  read_n,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    localparam edge_type_e EDGE_SEL = edge_type_e'(EDGE_TYPE[1:0]);

    logic [DATA_WIDTH-1:0] sync_out;
    logic [DATA_WIDTH-1:0] sync_d;
    logic                  armed;

    logic [DATA_WIDTH-1:0] rise, fall, edge_det;
    logic [DATA_WIDTH-1:0] clear;
    logic                  wr_en, rd_en;

    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] cap_q, cap_d;
    logic [31:0]           rdata_q, rdata_d;

    logic                  unused_wdata;

    nios_pio_sync #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i    (clk),
        .rst_i    (reset),
        .data_i   (in_port),
        .sync_o   (sync_out),
        .sync_d_o (sync_d),
        .armed_o  (armed)
    );

    assign rise = sync_out & ~sync_d;
    assign fall = ~sync_out & sync_d;

    always_comb begin
        edge_det = '0;
        case (EDGE_SEL)
            EDGE_RISING:  edge_det = rise;
            EDGE_FALLING: edge_det = fall;
            default:      edge_det = rise | fall;
        endcase
    end

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & ~read_n;

    always_comb begin
        clear   = '0;
        mask_d  = mask_q;
        rdata_d = rdata_q;
        if (wr_en && address == ADDR_IRQ_MASK) begin
            mask_d = writedata[DATA_WIDTH-1:0];
        end
        if (wr_en && address == ADDR_EDGE_CAPTURE) begin
            clear = writedata[DATA_WIDTH-1:0];
        end
        // Edge set is OR'd after the clear so a same-cycle edge survives.
        cap_d = (cap_q & ~clear) | (armed ? edge_det : '0);
        if (rd_en) begin
            case (address)
                ADDR_DATA:         rdata_d = 32'(sync_out);
                ADDR_IRQ_MASK:     rdata_d = 32'(mask_q);
                ADDR_EDGE_CAPTURE: rdata_d = 32'(cap_q);
                default:           rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q  <= '0;
            cap_q   <= '0;
            rdata_q <= '0;
        end else begin
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
        end
    end

    assign readdata     = rdata_q;
    assign irq          = |(cap_q & mask_q);
    assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_nios_pio_capture_in.sv
// Directed bench for nios_pio_capture_in: a rising-edge and an any-edge
// instance share the Avalon bus, each with its own input bus.
module tb_nios_pio_capture_in;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [11:0] in_r = 12'hFFF;
    logic [11:0] in_a = 12'h000;
    logic [31:0] readdata_r, readdata_a;
    logic        irq_r, irq_a;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    nios_pio_capture_in #(
        .DATA_WIDTH  (12),
        .SYNC_STAGES (2),
        .EDGE_TYPE   (0)
    ) dut_r (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_r),
        .readdata   (readdata_r),
        .irq        (irq_r)
    );

    nios_pio_capture_in #(
        .DATA_WIDTH  (12),
        .SYNC_STAGES (2),
        .EDGE_TYPE   (2)
    ) dut_a (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_a),
        .readdata   (readdata_a),
        .irq        (irq_a)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a);
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = a;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with the rising-edge bus held at all ones.
        #2 reset = 1'b1;
        #1;
        check("rst_irq", {31'b0, irq_r}, 32'h0);
        check("rst_readdata", readdata_r, 32'h0);
        tick(3);
        reset = 1'b0;
        tick(4);
        bus_rd(2'd3);
        check("arm_capture", readdata_r, 32'h0);
        check("arm_irq", {31'b0, irq_r}, 32'h0);
        bus_rd(2'd0);
        check("arm_data", readdata_r, 32'h0000_0FFF);

        // 000 -> 005 with mask 001: capture at edge k+2, irq follows.
        in_r = 12'h000;
        tick(4);
        bus_wr(2'd3, 32'hFFF);
        bus_rd(2'd3);
        check("clr_capture", readdata_r, 32'h0);
        bus_wr(2'd2, 32'h001);
        in_r = 12'h005;
        tick(2);
        check("lat_irq_k1", {31'b0, irq_r}, 32'h0);
        tick(1);
        check("lat_irq_k2", {31'b0, irq_r}, 32'h1);
        bus_rd(2'd3);
        check("cap_005", readdata_r, 32'h005);
        bus_rd(2'd0);
        check("data_005", readdata_r, 32'h005);
        bus_rd(2'd2);
        check("mask_rd", readdata_r, 32'h001);

        // Write-1-to-clear bit 0.
        bus_wr(2'd3, 32'h1);
        check("w1c_irq", {31'b0, irq_r}, 32'h0);
        bus_rd(2'd3);
        check("w1c_cap", readdata_r, 32'h004);

        // Rising edge on bit 3 coincides with a clear of bit 3.
        in_r = 12'h00D;
        tick(2);
        bus_wr(2'd3, 32'h8);
        bus_rd(2'd3);
        check("set_wins", readdata_r, 32'h00C);
        bus_wr(2'd3, 32'h8);
        bus_rd(2'd3);
        check("clr_bit3", readdata_r, 32'h004);

        // Mask 0 keeps irq low; enabling the mask raises it next cycle.
        bus_wr(2'd3, 32'hFFF);
        bus_wr(2'd2, 32'h000);
        in_r = 12'h000;
        tick(3);
        in_r = 12'h005;
        tick(3);
        check("mask0_irq", {31'b0, irq_r}, 32'h0);
        bus_rd(2'd3);
        check("mask0_cap", readdata_r, 32'h005);
        bus_wr(2'd2, 32'h001);
        check("mask1_irq", {31'b0, irq_r}, 32'h1);

        // Any-edge instance: bit 11 high, clear, then low.
        bus_wr(2'd3, 32'hFFF);
        in_a = 12'h800;
        tick(3);
        bus_rd(2'd3);
        check("any_rise", readdata_a, 32'h800);
        bus_wr(2'd3, 32'hFFF);
        bus_rd(2'd3);
        check("any_clr", readdata_a, 32'h000);
        in_a = 12'h000;
        tick(3);
        bus_rd(2'd3);
        check("any_fall", readdata_a, 32'h800);
        bus_rd(2'd1);
        check("rsvd_rd", readdata_r, 32'h0);
        bus_wr(2'd0, 32'hFFFF_FFFF);
        bus_rd(2'd0);
        check("data_ro", readdata_r, 32'h005);

        // Full capture and mask, then reset mid-cycle.
        bus_wr(2'd2, 32'hFFF);
        in_r = 12'h000;
        tick(3);
        bus_wr(2'd3, 32'hFFF);
        in_r = 12'hFFF;
        tick(3);
        bus_rd(2'd3);
        check("full_cap", readdata_r, 32'hFFF);
        check("full_irq", {31'b0, irq_r}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("async_irq", {31'b0, irq_r}, 32'h0);
        check("async_rdata", readdata_r, 32'h0);
        tick(2);
        reset = 1'b0;
        tick(4);
        check("rearm_irq", {31'b0, irq_r}, 32'h0);
        bus_rd(2'd3);
        check("rearm_cap", readdata_r, 32'h0);
        bus_rd(2'd2);
        check("rearm_mask", readdata_r, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
